// File: rtl/tone_dir_detector.sv
// Tone/button direction detector.
// A channel becomes the direction once it has been seen high for HOLD_CYCLES
// samples, with short low gaps (up to DROP_CYCLES) tolerated. After a detection
// the block stays locked until every input has been low for DROP_CYCLES+1
// samples, so a held button never fires twice.
//
// state  | meaning
// IDLE   | detection disabled, everything cleared
// ARM    | looking for / qualifying a candidate channel
// LOCKED | direction reported, waiting for all inputs to release
module tone_dir_detector #(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int DROP_CYCLES = 0,
  parameter int CNT_W       = 26,
  parameter int CODE_W      = 3,
  parameter int LATCH_MODE  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enableToneDetection,
  input  logic [NUM_CH-1:0] toneIn,
  output logic [CODE_W-1:0] toneDir,
  output logic              toneValid,
  output logic              toneLocked
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 64'd1;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] DROP_LIM = CNT_W'(DROP_CYCLES + 1);

  if (NUM_CH < 1 || NUM_CH > 15) begin : g_bad_num_ch
    $error("tone_dir_detector: NUM_CH must be 1..15");
  end
  if (HOLD_CYCLES < 1 || longint'(HOLD_CYCLES) > CNT_MAX) begin : g_bad_hold
    $error("tone_dir_detector: HOLD_CYCLES out of range for CNT_W");
  end
  if (DROP_CYCLES < 0 || longint'(DROP_CYCLES) + 64'd1 > CNT_MAX) begin : g_bad_drop
    $error("tone_dir_detector: DROP_CYCLES+1 out of range for CNT_W");
  end
  if ((64'd1 << CODE_W) < longint'(NUM_CH + 1)) begin : g_bad_code
    $error("tone_dir_detector: CODE_W too narrow for NUM_CH");
  end

  typedef enum logic [1:0] {IDLE, ARM, LOCKED} state_t;

  state_t            state, state_nxt;
  logic              cand_vld, cand_vld_nxt;
  logic [CH_W-1:0]   cand, cand_nxt;
  logic [CNT_W-1:0]  hold_cnt, hold_nxt;
  logic [CNT_W-1:0]  drop_cnt, drop_nxt;
  logic [CODE_W-1:0] dir_nxt;
  logic              valid_nxt;

  logic              any_hi;
  logic [CH_W-1:0]   sel_idx;
  logic              cand_hi;
  logic [CNT_W-1:0]  hold_inc, drop_inc;
  logic              do_det;
  logic [CH_W-1:0]   det_idx;

  // Lowest-index active channel wins when several are high together.
  always_comb begin
    any_hi  = 1'b0;
    sel_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (toneIn[i]) begin
        any_hi  = 1'b1;
        sel_idx = CH_W'(i);
      end
    end
  end

  assign cand_hi  = toneIn[cand];
  assign hold_inc = hold_cnt + CNT_W'(1);
  assign drop_inc = drop_cnt + CNT_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and datapath updates; disable overrides every state.
  always_comb begin
    state_nxt    = state;
    cand_vld_nxt = cand_vld;
    cand_nxt     = cand;
    hold_nxt     = hold_cnt;
    drop_nxt     = drop_cnt;
    dir_nxt      = toneDir;
    valid_nxt    = 1'b0;
    do_det       = 1'b0;
    det_idx      = cand;
    if (!enableToneDetection) begin
      state_nxt    = IDLE;
      cand_vld_nxt = 1'b0;
      cand_nxt     = '0;
      hold_nxt     = '0;
      drop_nxt     = '0;
      dir_nxt      = '0;
    end else begin
      case (state)
        IDLE: state_nxt = ARM;
        ARM: begin
          if (!cand_vld) begin
            if (any_hi) begin
              if (HOLD_LIM == CNT_W'(1)) begin
                do_det  = 1'b1;
                det_idx = sel_idx;
              end else begin
                cand_vld_nxt = 1'b1;
                cand_nxt     = sel_idx;
                hold_nxt     = CNT_W'(1);
                drop_nxt     = '0;
              end
            end
          end else if (cand_hi) begin
            drop_nxt = '0;
            if (hold_inc == HOLD_LIM) do_det = 1'b1;
            else                      hold_nxt = hold_inc;
          end else if (drop_inc == DROP_LIM) begin
            // Candidate lost: forget it silently, reselect next edge.
            cand_vld_nxt = 1'b0;
            cand_nxt     = '0;
            hold_nxt     = '0;
            drop_nxt     = '0;
          end else begin
            drop_nxt = drop_inc;
          end
        end
        LOCKED: begin
          if (any_hi) begin
            drop_nxt = '0;
          end else if (drop_inc == DROP_LIM) begin
            state_nxt = ARM;
            drop_nxt  = '0;
            if (LATCH_MODE == 0) dir_nxt = '0;
          end else begin
            drop_nxt = drop_inc;
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (do_det) begin
        state_nxt    = LOCKED;
        dir_nxt      = CODE_W'(det_idx) + CODE_W'(1);
        valid_nxt    = 1'b1;
        cand_vld_nxt = 1'b0;
        cand_nxt     = '0;
        hold_nxt     = '0;
        drop_nxt     = '0;
      end
    end
  end

  // Candidate, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand_vld  <= 1'b0;
      cand      <= '0;
      hold_cnt  <= '0;
      drop_cnt  <= '0;
      toneDir   <= '0;
      toneValid <= 1'b0;
    end else begin
      cand_vld  <= cand_vld_nxt;
      cand      <= cand_nxt;
      hold_cnt  <= hold_nxt;
      drop_cnt  <= drop_nxt;
      toneDir   <= dir_nxt;
      toneValid <= valid_nxt;
    end
  end

  // Lock indication follows the state register directly.
  always_comb begin
    toneLocked = (state == LOCKED);
  end

endmodule

// File: tb/tb_tone_dir_detector.sv
// Directed bench: three detectors share one stimulus stream
// (latching, non-latching, and single-sample hold).
module tb_tone_dir_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] tone;

  logic [2:0] dir_l, dir_n, dir_1;
  logic       vld_l, vld_n, vld_1;
  logic       lck_l, lck_n, lck_1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tone_dir_detector #(.NUM_CH(4), .HOLD_CYCLES(8), .DROP_CYCLES(2), .CNT_W(26),
                      .CODE_W(3), .LATCH_MODE(1)) dut (
    .clk(clk), .rst(rst), .enableToneDetection(en), .toneIn(tone),
    .toneDir(dir_l), .toneValid(vld_l), .toneLocked(lck_l));

  tone_dir_detector #(.NUM_CH(4), .HOLD_CYCLES(8), .DROP_CYCLES(2), .CNT_W(26),
                      .CODE_W(3), .LATCH_MODE(0)) dut_nl (
    .clk(clk), .rst(rst), .enableToneDetection(en), .toneIn(tone),
    .toneDir(dir_n), .toneValid(vld_n), .toneLocked(lck_n));

  tone_dir_detector #(.NUM_CH(4), .HOLD_CYCLES(1), .DROP_CYCLES(2), .CNT_W(26),
                      .CODE_W(3), .LATCH_MODE(1)) dut_h1 (
    .clk(clk), .rst(rst), .enableToneDetection(en), .toneIn(tone),
    .toneDir(dir_1), .toneValid(vld_1), .toneLocked(lck_1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply n edges with no toneValid expected on the latching DUT.
  task automatic quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, vld_l, 1'b0);
    end
  endtask

  // Release all inputs for the three edges needed to leave LOCKED.
  task automatic release3();
    tone = 4'b0000;
    tick(); tick();
    chk("rel_still_locked", lck_l, 1'b1);
    tick();
    chk("rel_armed", lck_l, 1'b0);
  endtask

  initial begin
    rst  = 1'b0;
    en   = 1'b0;
    tone = 4'b0000;
    #1;
    chk("rst_dir", dir_l, 3'd0);
    chk("rst_vld", vld_l, 1'b0);
    chk("rst_lck", lck_l, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Basic hold on channel 2.
    en = 1'b1;
    tick();                      // IDLE -> ARM
    tone = 4'b0100;
    tick();                      // selection edge, first high
    chk("h1_vld", vld_1, 1'b1);
    chk("h1_dir", dir_1, 3'd3);
    chk("basic_no_early", vld_l, 1'b0);
    quiet(5, "basic_quiet");     // highs 2..6
    tick();                      // high 7
    chk("basic_7th", vld_l, 1'b0);
    chk("basic_7th_dir", dir_l, 3'd0);
    tick();                      // high 8
    chk("basic_vld", vld_l, 1'b1);
    chk("basic_dir", dir_l, 3'd3);
    chk("basic_lck", lck_l, 1'b1);
    tick();
    chk("basic_pulse_end", vld_l, 1'b0);

    // Held input must never re-fire.
    quiet(20, "hold_no_refire");
    chk("hold_dir", dir_l, 3'd3);
    tone = 4'b0000;
    tick(); tick();
    chk("rel2_lck", lck_l, 1'b1);
    tick();
    chk("rel3_lck", lck_l, 1'b0);
    chk("rel_latch_dir", dir_l, 3'd3);
    chk("rel_nolatch_dir", dir_n, 3'd0);

    // Channel 3 after re-arm.
    tone = 4'b1000;
    quiet(7, "ch3_quiet");
    tick();
    chk("ch3_vld", vld_l, 1'b1);
    chk("ch3_dir", dir_l, 3'd4);
    chk("ch3_dir_nl", dir_n, 3'd4);
    release3();
    chk("ch3_rel_nl", dir_n, 3'd0);

    // Priority: two simultaneous highs pick the lower index.
    tone = 4'b0110;
    quiet(7, "prio_quiet");
    tick();
    chk("prio_dir", dir_l, 3'd2);
    chk("prio_vld", vld_l, 1'b1);
    release3();

    // No preemption by a lower channel joining later.
    tone = 4'b0100;
    quiet(3, "nopre_a");
    tone = 4'b0110;
    quiet(4, "nopre_b");
    tick();
    chk("nopre_dir", dir_l, 3'd3);
    chk("nopre_vld", vld_l, 1'b1);
    release3();

    // Glitch of two lows is tolerated.
    tone = 4'b0001;
    quiet(4, "gl_hi1");
    tone = 4'b0000;
    quiet(2, "gl_lo");
    tone = 4'b0001;
    quiet(3, "gl_hi2");
    tick();
    chk("gl_vld", vld_l, 1'b1);
    chk("gl_dir", dir_l, 3'd1);
    release3();

    // Three lows lose the candidate and counting restarts.
    tone = 4'b0001;
    quiet(4, "gl3_hi1");
    tone = 4'b0000;
    quiet(3, "gl3_lo");
    chk("gl3_dir_kept", dir_l, 3'd1);
    chk("gl3_nl_dir", dir_n, 3'd0);
    chk("gl3_not_locked", lck_l, 1'b0);
    tone = 4'b0001;
    quiet(7, "gl3_restart");
    tick();
    chk("gl3_vld", vld_l, 1'b1);
    chk("gl3_dir", dir_l, 3'd1);
    release3();

    // Disable at hold count 5.
    tone = 4'b0100;
    quiet(5, "dis_hi");
    en = 1'b0;
    tick();
    chk("dis_dir", dir_l, 3'd0);
    chk("dis_vld", vld_l, 1'b0);
    chk("dis_lck", lck_l, 1'b0);
    en = 1'b1;
    tick();                      // IDLE -> ARM
    quiet(7, "dis_restart");
    tick();
    chk("dis_re_vld", vld_l, 1'b1);
    chk("dis_re_dir", dir_l, 3'd3);

    // Asynchronous reset while locked, checked before any clock edge.
    tick();
    chk("ar_pre_lck", lck_l, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_dir", dir_l, 3'd0);
    chk("ar_vld", vld_l, 1'b0);
    chk("ar_lck", lck_l, 1'b0);
    tick();
    rst = 1'b1;
    tick();                      // IDLE -> ARM
    quiet(7, "ar_restart");
    tick();
    chk("ar_re_vld", vld_l, 1'b1);
    chk("ar_re_dir", dir_l, 3'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_dir_detector.md
TONE_DIR_DETECTOR -- requirements
Module: tone_dir_detector

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of tone/button input channels, 1..15.
REQ-002 SHALL have parameter HOLD_CYCLES, default 50_000_000: consecutive high samples required to declare a channel, at least 1.
REQ-003 SHALL have parameter DROP_CYCLES, default 0: consecutive low samples tolerated on the candidate without losing progress.
REQ-004 SHALL have parameter CNT_W, default 26: hold/drop counter width; elaboration fails if HOLD_CYCLES or DROP_CYCLES+1 exceeds 2^CNT_W-1.
REQ-005 SHALL have parameter CODE_W, default 3: toneDir width; elaboration fails if 2^CODE_W < NUM_CH+1.
REQ-006 SHALL have parameter LATCH_MODE, default 1: 1 = toneDir holds after release; 0 = toneDir returns to 0 on release.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port enableToneDetection, input, 1 bit: level enable.
REQ-010 SHALL have port toneIn, input, NUM_CH bits: channel request levels, already synchronous to clk.
REQ-011 SHALL have port toneDir, output, CODE_W bits: detected direction; 0 = hold/none, channel i = i+1.
REQ-012 SHALL have port toneValid, output, 1 bit: one-cycle pulse when toneDir is updated by a detection.
REQ-013 SHALL have port toneLocked, output, 1 bit: high while in LOCKED.

Function
REQ-014 SHALL implement a state machine with states IDLE, ARM and LOCKED.
REQ-015 SHALL hold one candidate channel index, one hold counter and one drop counter.
REQ-016 SHALL leave IDLE for ARM at the first edge where enable is sampled high.
REQ-017 SHALL, in any state, on an edge where enable is sampled low: go to IDLE, clear candidate and counters, and set toneDir=0 and toneValid=0.
REQ-018 SHALL, in ARM with no candidate, select the lowest-index high bit of toneIn as candidate; the hold counter becomes 1 on that edge.
REQ-019 SHALL give the lowest index priority when several bits are high together; once a candidate is selected, other channels are ignored until it is cleared.
REQ-020 SHALL, per edge with the candidate sampled high, increment the hold counter and clear the drop counter.
REQ-021 SHALL, per edge with the candidate sampled low, freeze the hold counter and increment the drop counter.
REQ-022 SHALL, on the (DROP_CYCLES+1)-th consecutive low sample of the candidate, clear the candidate and both counters with no output change; reselection is allowed on the next edge.
REQ-023 SHALL detect on the edge at which the candidate's HOLD_CYCLES-th high sample (cumulative, drops tolerated) is taken: toneDir=candidate+1, toneValid=1 for exactly that one cycle, state to LOCKED, counters cleared.
REQ-024 SHALL, with HOLD_CYCLES=1, detect on the selection edge itself.
REQ-025 SHALL, in LOCKED, count consecutive edges with toneIn all low, and on the (DROP_CYCLES+1)-th go to ARM; any high bit restarts this count.
REQ-026 SHALL, on LOCKED to ARM with LATCH_MODE=0, set toneDir=0 on the same edge; with LATCH_MODE=1, toneDir is unchanged.
REQ-027 SHALL produce no detection and no toneValid while in LOCKED, so a held input never re-fires.
REQ-028 SHALL saturate neither counter silently; REQ-004 guarantees neither wraps.

Reset
REQ-029 SHALL, while rst=0, immediately force state IDLE, candidate 0, counters 0, toneDir=0, toneValid=0 and toneLocked=0, including mid-count and mid-LOCKED.
REQ-030 SHALL, after rst deasserts, start from IDLE with no memory of the prior candidate.

Verification
(parameters for all: NUM_CH=4, HOLD_CYCLES=8, DROP_CYCLES=2, LATCH_MODE=1)
REQ-031 SHALL test a basic hold: enable=1, toneIn=0100 steady -> toneDir=3 and toneValid pulse on the 8th high edge, toneLocked=1.
REQ-032 SHALL test priority and no preemption: toneIn=0110 from the start -> toneDir=2; and toneIn=0100 for 3 edges then 0110 -> still toneDir=3 after 8 cumulative highs.
REQ-033 SHALL test glitch tolerance: channel 0 high 4, low 2, high 4 -> detect on the 4th high of the second burst; low 3 instead -> no detect, counting restarts.
REQ-034 SHALL test release and re-arm: after a detect, hold input 20 edges -> no second toneValid; all low for 3 edges -> ARM; hold channel 3 for 8 edges -> toneDir=4; repeat with LATCH_MODE=0 -> toneDir=0 on release.
REQ-035 SHALL test disable and reset mid-operation: enable=0 at hold count 5 -> toneDir=0 next edge and counters cleared; rst=0 asynchronously while LOCKED -> all outputs 0 without a clock edge.
